// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the lane geometry of one memory word.
package mem_access_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_BITS      = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: extracts and extends sub-word load data, and
// merges a sub-word store into the word read back from memory.
module lane_align
  import mem_access_pkg::*;
#(
  parameter int LEN_WORD = 32
) (
  input  logic [LANE_BITS-1:0] lane_i,
  input  size_e                size_i,
  input  logic                 signed_i,
  input  logic [LEN_WORD-1:0]  rdata_i,
  input  logic [LEN_WORD-1:0]  wdata_i,
  output logic [LEN_WORD-1:0]  load_o,
  output logic [LEN_WORD-1:0]  merge_o
);

  logic [LANE_BITS+2:0] shamt;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [LEN_WORD-1:0]  mask;
  logic [LEN_WORD-1:0]  lane_data;

  // Half-word lanes fall out of the byte shift because addr[0] is 0 for them.
  always_comb begin
    shamt     = {lane_i, 3'b000};
    byte_v    = 8'(rdata_i >> shamt);
    half_v    = 16'(rdata_i >> shamt);
    load_o    = rdata_i;
    mask      = '1;
    lane_data = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_o    = {{(LEN_WORD-8){signed_i & byte_v[7]}}, byte_v};
        mask      = LEN_WORD'(8'hFF) << shamt;
        lane_data = LEN_WORD'(wdata_i[7:0]) << shamt;
      end
      SIZE_H: begin
        load_o    = {{(LEN_WORD-16){signed_i & half_v[15]}}, half_v};
        mask      = LEN_WORD'(16'hFFFF) << shamt;
        lane_data = LEN_WORD'(wdata_i[15:0]) << shamt;
      end
      default: ;
    endcase
    merge_o = (rdata_i & ~mask) | (lane_data & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: accepts byte-addressed requests, checks them,
// and drives a word-addressed memory, using read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int LEN_WORD = 32,
  parameter int SIZE_MEM = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [LEN_WORD-1:0] req_addr,
  input  logic [LEN_WORD-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [LEN_WORD-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [LEN_WORD-1:0] mem_address,
  output logic [LEN_WORD-1:0] mem_wdata,
  input  logic [LEN_WORD-1:0] mem_rdata
);

  localparam logic [LEN_WORD-1:0] MEM_WORDS = LEN_WORD'(SIZE_MEM);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  size_e               size_q, size_d;
  logic                signed_q, signed_d;
  logic [LEN_WORD-1:0] addr_q, addr_d;
  logic [LEN_WORD-1:0] wdata_q, wdata_d;
  logic [LEN_WORD-1:0] merge_q, merge_d;
  logic [LEN_WORD-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_bad;
  logic [LEN_WORD-1:0] load_data;
  logic [LEN_WORD-1:0] merge_data;

  lane_align #(.LEN_WORD(LEN_WORD)) u_lane_align (
    .lane_i   (addr_q[LANE_BITS-1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_i  (mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SIZE_B;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    req_bad = (req_size == SIZE_X)
           || (req_size == SIZE_H && req_addr[0])
           || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
           || ((req_addr >> LANE_BITS) >= MEM_WORDS);
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          merge_d  = '0;
          rdata_d  = '0;
          err_d    = req_bad;
          if (req_bad)                 state_d = RESP;
          else if (!req_write)         state_d = READ;
          else if (req_size == SIZE_W) state_d = WRITE;
          else                         state_d = RMW_READ;
        end
      end
      READ: begin
        mem_read_en = 1'b1;
        mem_address = addr_q >> LANE_BITS;
        rdata_d     = load_data;
        state_d     = RESP;
      end
      RMW_READ: begin
        mem_read_en = 1'b1;
        mem_address = addr_q >> LANE_BITS;
        merge_d     = merge_data;
        state_d     = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        mem_address  = addr_q >> LANE_BITS;
        mem_wdata    = (size_q == SIZE_W) ? wdata_q : merge_q;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must never commit a write or present a response.
    if (reset) begin
      rsp_valid    = 1'b0;
      rsp_rdata    = '0;
      rsp_err      = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_address  = '0;
      mem_wdata    = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan steps plus random
// requests checked against a byte-level reference memory model.
module tb_mem_access_unit;

  localparam int LEN_WORD = 32;
  localparam int SIZE_MEM = 1024;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [LEN_WORD-1:0] req_addr;
  logic [LEN_WORD-1:0] req_wdata;
  logic                rsp_valid;
  logic [LEN_WORD-1:0] rsp_rdata;
  logic                rsp_err;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [LEN_WORD-1:0] mem_address;
  logic [LEN_WORD-1:0] mem_wdata;
  logic [LEN_WORD-1:0] mem_rdata;

  logic [31:0] data_mem [SIZE_MEM];
  logic [31:0] ref_mem  [SIZE_MEM];

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.LEN_WORD(LEN_WORD), .SIZE_MEM(SIZE_MEM)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT: asynchronous read, write on the clock edge.
  assign mem_rdata = mem_read_en ? data_mem[mem_address[9:0]] : '0;

  always @(posedge clk) begin
    if (mem_write_en) data_mem[mem_address[9:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Reference model: treats a word as four bytes, applies the access rules
  // directly, and updates ref_mem for stores.
  task automatic modelReq(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output bit err, output logic [31:0] rdata, output int lat,
                          output bit expWrite, output logic [31:0] expWAddr,
                          output logic [31:0] expWData);
    longint unsigned idx, lo, nbytes, value;
    logic [7:0] bytes [4];
    logic [31:0] word;
    idx      = longint'(addr) / 4;
    lo       = longint'(addr) % 4;
    nbytes   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    err      = (sz == 3) || (sz == 1 && lo % 2 != 0) || (sz == 2 && lo != 0) || (idx >= SIZE_MEM);
    rdata    = '0;
    expWrite = 1'b0;
    expWAddr = '0;
    expWData = '0;
    lat      = 1;
    if (!err) begin
      word = ref_mem[idx];
      for (int b = 0; b < 4; b++) bytes[b] = word[8*b +: 8];
      if (!wr) begin
        value = 0;
        for (longint unsigned b = 0; b < nbytes; b++)
          value = value + longint'(bytes[lo+b]) * (longint'(1) << (8*b));
        if (sg && nbytes < 4 && value >= (longint'(1) << (8*nbytes-1)))
          value = value + 64'h1_0000_0000 - (longint'(1) << (8*nbytes));
        rdata = 32'(value);
        lat   = 2;
      end else begin
        for (longint unsigned b = 0; b < nbytes; b++)
          bytes[lo+b] = wd[8*b +: 8];
        word = {bytes[3], bytes[2], bytes[1], bytes[0]};
        ref_mem[idx] = word;
        expWrite = 1'b1;
        expWAddr = 32'(idx);
        expWData = word;
        lat      = (sz == 2) ? 2 : 3;
      end
    end
  endtask

  // Issues one request, then watches the memory side and the response.
  task automatic applyStimulus(input string tag, input bit wr, input logic [1:0] sz,
                               input bit sg, input logic [31:0] addr, input logic [31:0] wd);
    bit err, expWrite, got;
    logic [31:0] expRdata, expWAddr, expWData, wa, wdv, rr;
    logic re;
    int lat, obsLat, reads, writes, both, waitCycles;
    modelReq(wr, sz, sg, addr, wd, err, expRdata, lat, expWrite, expWAddr, expWData);
    waitCycles = 0;
    while (!req_ready && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    got = 0; obsLat = 0; reads = 0; writes = 0; both = 0;
    wa = '0; wdv = '0; rr = '0; re = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (mem_read_en && mem_write_en) both++;
      if (mem_read_en) reads++;
      if (mem_write_en) begin writes++; wa = mem_address; wdv = mem_wdata; end
      if (rsp_valid) begin got = 1; obsLat = c + 1; rr = rsp_rdata; re = rsp_err; end
    end
    checkOutput({tag, " rsp_seen"}, 32'(got), 32'd1);
    checkOutput({tag, " latency"}, 32'(obsLat), 32'(lat));
    checkOutput({tag, " rdata"}, rr, expRdata);
    checkOutput({tag, " err"}, 32'(re), 32'(err));
    checkOutput({tag, " writes"}, 32'(writes), 32'(expWrite));
    checkOutput({tag, " rd_wr_overlap"}, 32'(both), 32'd0);
    if (err) checkOutput({tag, " reads_on_err"}, 32'(reads), 32'd0);
    if (expWrite) begin
      checkOutput({tag, " waddr"}, wa, expWAddr);
      checkOutput({tag, " wdata"}, wdv, expWData);
    end
    @(posedge clk); #1;
    checkOutput({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    bit err, expWrite, bad;
    logic [31:0] expRdata, expWAddr, expWData, swData, a;
    logic [1:0] sz;
    int lat, r;

    for (int i = 0; i < SIZE_MEM; i++) begin
      data_mem[i] = 32'(i);
      ref_mem[i]  = 32'(i);
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    checkOutput("reset mem_address", mem_address, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);

    $display("[TB] directed loads and sub-word stores");
    applyStimulus("LW 0x14", 0, 2, 0, 32'h14, 32'h0);
    applyStimulus("SB 0x09", 1, 0, 0, 32'h09, 32'h80);
    applyStimulus("LB 0x09", 0, 0, 1, 32'h09, 32'h0);
    applyStimulus("LBU 0x09", 0, 0, 0, 32'h09, 32'h0);
    applyStimulus("SH 0x0E", 1, 1, 0, 32'h0E, 32'hBEEF);
    applyStimulus("LH 0x0E", 0, 1, 1, 32'h0E, 32'h0);
    applyStimulus("LHU 0x0E", 0, 1, 0, 32'h0E, 32'h0);
    checkOutput("SB word 2 content", data_mem[2], 32'h0000_8002);
    checkOutput("SH word 3 content", data_mem[3], 32'hBEEF_0003);

    $display("[TB] error requests");
    applyStimulus("LH misaligned", 0, 1, 1, 32'h03, 32'h0);
    applyStimulus("SW misaligned", 1, 2, 0, 32'h06, 32'hDEAD_BEEF);
    applyStimulus("size 3", 0, 3, 0, 32'h10, 32'h0);
    applyStimulus("LW out of range", 0, 2, 0, 32'(4*SIZE_MEM), 32'h0);
    applyStimulus("SB out of range", 1, 0, 0, 32'(4*SIZE_MEM + 1), 32'h55);

    $display("[TB] back-to-back with req_valid held");
    swData = $urandom;
    modelReq(1, 2, 0, 32'h0, swData, err, expRdata, lat, expWrite, expWAddr, expWData);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = swData;
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = $urandom;
    checkOutput("b2b ready busy1", 32'(req_ready), 32'd0);
    checkOutput("b2b SW write", {31'd0, mem_write_en}, 32'd1);
    checkOutput("b2b SW wdata", mem_wdata, expWData);
    @(posedge clk); #1;
    checkOutput("b2b ready busy2", 32'(req_ready), 32'd0);
    checkOutput("b2b SW rsp", {30'd0, rsp_valid, rsp_err}, 32'h2);
    @(posedge clk); #1;
    checkOutput("b2b ready back", 32'(req_ready), 32'd1);
    modelReq(0, 2, 0, 32'h0, 32'h0, err, expRdata, lat, expWrite, expWAddr, expWData);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("b2b LW read", {31'd0, mem_read_en}, 32'd1);
    @(posedge clk); #1;
    checkOutput("b2b LW rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("b2b LW rdata", rsp_rdata, expRdata);

    $display("[TB] random requests");
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, 4*SIZE_MEM - 1));
      if ($urandom_range(0, 9) < 7 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      applyStimulus($sformatf("rand%0d", n), 1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    $display("[TB] reset during RMW_READ");
    a = 32'($urandom_range(0, 63));
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = a; req_wdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("abort rmw read", {31'd0, mem_read_en}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort write in reset", {31'd0, mem_write_en}, 32'd0);
    @(posedge clk); #1;
    bad = mem_write_en || rsp_valid;
    reset = 1'b0;
    #1;
    checkOutput("abort ready after reset", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (mem_write_en || rsp_valid) bad = 1'b1;
    end
    checkOutput("abort no write/rsp", 32'(bad), 32'd0);
    applyStimulus("abort mem intact", 0, 2, 0, a & ~32'd3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
